// File: rtl/ctrl_buf_mc.sv
// ctrl_buf_mc: NUM_CH independent circular FIFOs sharing one flop array,
// with per-channel enqueue, an internal dequeue arbiter (round-robin or
// fixed priority) and per-channel occupancy outputs.
// Optional macro CTRL_BUF_MC_DROP_CNT_EN adds a saturating 32-bit drop_cnt
// output counting enqueue attempts against a full channel.
module ctrl_buf_mc #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned ARB_MODE = 0,
  localparam int unsigned CH_W    = $clog2(NUM_CH),
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_enque_en,
  input  logic [CH_W-1:0]         in_ch,
  input  logic [DWIDTH-1:0]       in_data,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    out_deque_en,
  output logic                    out_valid,
  output logic [CH_W-1:0]         out_ch,
  output logic [DWIDTH-1:0]       out_data,
  output logic [NUM_CH*CNT_W-1:0] occupancy
`ifdef CTRL_BUF_MC_DROP_CNT_EN
  ,
  output logic [31:0]             drop_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem  [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  head [NUM_CH];
  logic [PTR_W-1:0]  tail [NUM_CH];
  logic [CNT_W-1:0]  cnt  [NUM_CH];
  logic [CH_W-1:0]   rr_ptr;

  logic [CH_W-1:0]   sel;
  logic              any_valid;
  logic              deq_fire;
  logic [NUM_CH-1:0] enq_v;
  logic [NUM_CH-1:0] deq_v;
  int                scan_idx;

  // Pointers wrap explicitly so DEPTH need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Readiness and occupancy straight from the registered counts
  always_comb begin
    in_ready  = '0;
    occupancy = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      in_ready[c]                  = (cnt[c] != CNT_W'(DEPTH));
      occupancy[c*CNT_W +: CNT_W]  = cnt[c];
    end
  end

  // Dequeue arbiter: scan from rr_ptr (round-robin) or from channel 0
  always_comb begin
    sel       = '0;
    any_valid = 1'b0;
    scan_idx  = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ARB_MODE == 0) begin
        scan_idx = int'(rr_ptr) + i;
        if (scan_idx >= int'(NUM_CH)) scan_idx = scan_idx - int'(NUM_CH);
      end else begin
        scan_idx = i;
      end
      if (!any_valid && (cnt[CH_W'(scan_idx)] != '0)) begin
        any_valid = 1'b1;
        sel       = CH_W'(scan_idx);
      end
    end
  end

  assign out_valid = any_valid;
  assign out_ch    = sel;
  assign out_data  = mem[sel][head[sel]];
  assign deq_fire  = out_deque_en && any_valid;

  // Per-channel accept strobes; enqueue sees only the registered count
  always_comb begin
    enq_v = '0;
    deq_v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      enq_v[c] = in_enque_en && (in_ch == CH_W'(c)) && (cnt[c] != CNT_W'(DEPTH));
      deq_v[c] = deq_fire && (sel == CH_W'(c));
    end
  end

  // Storage, pointers, counts and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        head[c] <= '0;
        tail[c] <= '0;
        cnt[c]  <= '0;
        for (int d = 0; d < DEPTH; d++) mem[c][d] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (enq_v[c]) begin
          mem[c][tail[c]] <= in_data;
          tail[c]         <= ptr_inc(tail[c]);
        end
        if (deq_v[c]) head[c] <= ptr_inc(head[c]);
        case ({enq_v[c], deq_v[c]})
          2'b10:   cnt[c] <= cnt[c] + CNT_W'(1);
          2'b01:   cnt[c] <= cnt[c] - CNT_W'(1);
          default: cnt[c] <= cnt[c];
        endcase
      end
      if ((ARB_MODE == 0) && deq_fire)
        rr_ptr <= (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + CH_W'(1);
    end
  end

`ifdef CTRL_BUF_MC_DROP_CNT_EN
  logic drop_c;

  // Enqueue attempt against a full target channel
  always_comb begin
    drop_c = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (in_enque_en && (in_ch == CH_W'(c)) && (cnt[c] == CNT_W'(DEPTH))) drop_c = 1'b1;
  end

  // Saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          drop_cnt <= '0;
    else if (drop_c && (drop_cnt != '1)) drop_cnt <= drop_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ctrl_buf_mc.sv
// Directed self-checking bench for ctrl_buf_mc (NUM_CH=4, DEPTH=4, DWIDTH=32).
// Two instances share the inputs: u_rr (round-robin) and u_fp (fixed priority).
module tb_ctrl_buf_mc;

  localparam int unsigned NCH = 4;
  localparam int unsigned DEP = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 2;
  localparam int unsigned NW  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_enque_en = 1'b0;
  logic [CW-1:0] in_ch = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_deque_en = 1'b0;

  logic [NCH-1:0]    rdy_rr, rdy_fp;
  logic              vld_rr, vld_fp;
  logic [CW-1:0]     ch_rr, ch_fp;
  logic [DW-1:0]     dat_rr, dat_fp;
  logic [NCH*NW-1:0] occ_rr, occ_fp;
`ifdef CTRL_BUF_MC_DROP_CNT_EN
  logic [31:0]       drop_rr, drop_fp;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ctrl_buf_mc #(.DWIDTH(DW), .DEPTH(DEP), .NUM_CH(NCH), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_enque_en(in_enque_en), .in_ch(in_ch),
    .in_data(in_data), .in_ready(rdy_rr), .out_deque_en(out_deque_en),
    .out_valid(vld_rr), .out_ch(ch_rr), .out_data(dat_rr), .occupancy(occ_rr)
`ifdef CTRL_BUF_MC_DROP_CNT_EN
    , .drop_cnt(drop_rr)
`endif
  );

  ctrl_buf_mc #(.DWIDTH(DW), .DEPTH(DEP), .NUM_CH(NCH), .ARB_MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_enque_en(in_enque_en), .in_ch(in_ch),
    .in_data(in_data), .in_ready(rdy_fp), .out_deque_en(out_deque_en),
    .out_valid(vld_fp), .out_ch(ch_fp), .out_data(dat_fp), .occupancy(occ_fp)
`ifdef CTRL_BUF_MC_DROP_CNT_EN
    , .drop_cnt(drop_fp)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NW-1:0] occ_of(input logic [NCH*NW-1:0] o, input int c);
    return o[c*NW +: NW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input int c, input logic [DW-1:0] d);
    in_enque_en = 1'b1;
    in_ch       = CW'(c);
    in_data     = d;
    tick();
    in_enque_en = 1'b0;
  endtask

  task automatic deq();
    out_deque_en = 1'b1;
    tick();
    out_deque_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_ready", 64'(rdy_rr), 64'hF);
    check("rst_valid", 64'(vld_rr), 64'h0);
    check("rst_occ",   64'(occ_rr), 64'h0);
    check("rst_ch",    64'(ch_rr),  64'h0);
    check("rst_data",  64'(dat_rr), 64'h0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", 64'(rdy_rr), 64'hF);
    check("idle_valid", 64'(vld_rr), 64'h0);

    // Fill ch2, overflow by one, drain in order
    for (int i = 0; i < 5; i++) enq(2, 32'h11 + 32'(i));
    check("full_occ2",  64'(occ_of(occ_rr, 2)), 64'd4);
    check("full_ready", 64'(rdy_rr), 64'b1011);
    check("full_valid", 64'(vld_rr), 64'h1);
`ifdef CTRL_BUF_MC_DROP_CNT_EN
    check("drop_one", 64'(drop_rr), 64'd1);
`endif
    for (int i = 0; i < 4; i++) begin
      check("drain_ch",   64'(ch_rr),  64'd2);
      check("drain_data", 64'(dat_rr), 64'h11 + 64'(i));
      deq();
    end
    check("drain_empty", 64'(vld_rr), 64'h0);
    check("drain_occ",   64'(occ_rr), 64'h0);

    // Pointer wrap-around on ch1
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) enq(1, 32'(r*3 + k));
      for (int k = 0; k < 3; k++) begin
        check("wrap_ch",   64'(ch_rr),  64'd1);
        check("wrap_data", 64'(dat_rr), 64'(r*3 + k));
        deq();
      end
    end
    check("wrap_empty", 64'(vld_rr), 64'h0);

    // Reset asserted mid-traffic
    enq(0, 32'hDEAD);
    enq(2, 32'hBEEF);
    in_enque_en = 1'b1;
    in_ch       = 2'd3;
    in_data     = 32'h5555;
    rst_n       = 1'b0;
    #1;
    check("midrst_ready", 64'(rdy_rr), 64'hF);
    check("midrst_valid", 64'(vld_rr), 64'h0);
    check("midrst_occ",   64'(occ_rr), 64'h0);
    tick();
    check("midrst_hold_valid", 64'(vld_rr), 64'h0);
    check("midrst_hold_occ",   64'(occ_rr), 64'h0);
    check("midrst_hold_data",  64'(dat_rr), 64'h0);
    in_enque_en = 1'b0;
    rst_n       = 1'b1;
    tick();
    check("postrst_valid", 64'(vld_rr), 64'h0);
`ifdef CTRL_BUF_MC_DROP_CNT_EN
    check("postrst_drop", 64'(drop_rr), 64'd0);
`endif

    // Round-robin grant order
    enq(0, 32'hA0);
    enq(1, 32'hA1);
    enq(3, 32'hA3);
    check("rr_g0_ch", 64'(ch_rr), 64'd0);
    check("rr_g0_d",  64'(dat_rr), 64'hA0);
    deq();
    check("rr_g1_ch", 64'(ch_rr), 64'd1);
    check("rr_g1_d",  64'(dat_rr), 64'hA1);
    deq();
    check("rr_g2_ch", 64'(ch_rr), 64'd3);
    check("rr_g2_d",  64'(dat_rr), 64'hA3);
    deq();
    check("rr_empty", 64'(vld_rr), 64'h0);
    // rr_ptr is 0 after serving ch3: scan from 0 picks ch0 first
    enq(3, 32'hB3);
    enq(0, 32'hB0);
    check("rr_refill_ch", 64'(ch_rr), 64'd0);
    deq();
    check("rr_refill2_ch", 64'(ch_rr), 64'd3);
    check("rr_refill2_d",  64'(dat_rr), 64'hB3);
    deq();
    // ch0 twice, ch2 once: rotation serves ch2 between the two ch0 entries
    enq(0, 32'hC0);
    enq(0, 32'hC1);
    enq(2, 32'hC2);
    check("rr_rot0_d", 64'(dat_rr), 64'hC0);
    deq();
    check("rr_rot1_ch", 64'(ch_rr), 64'd2);
    check("rr_rot1_d",  64'(dat_rr), 64'hC2);
    deq();
    check("rr_rot2_ch", 64'(ch_rr), 64'd0);
    check("rr_rot2_d",  64'(dat_rr), 64'hC1);
    deq();
    check("rr_rot_empty", 64'(vld_rr), 64'h0);

    // Fixed priority: ch0 jumps ahead of the second ch3 entry
    do_reset();
    enq(3, 32'hD0);
    enq(3, 32'hD1);
    check("fp_first_ch", 64'(ch_fp), 64'd3);
    check("fp_first_d",  64'(dat_fp), 64'hD0);
    deq();
    enq(0, 32'hE0);
    check("fp_pre_ch", 64'(ch_fp), 64'd0);
    check("fp_pre_d",  64'(dat_fp), 64'hE0);
    deq();
    check("fp_last_ch", 64'(ch_fp), 64'd3);
    check("fp_last_d",  64'(dat_fp), 64'hD1);
    deq();
    check("fp_empty", 64'(vld_fp), 64'h0);

    // Full channel with simultaneous enqueue and dequeue
    do_reset();
    for (int i = 0; i < 4; i++) enq(1, 32'hF0 + 32'(i));
    check("sim_full_occ", 64'(occ_of(occ_rr, 1)), 64'd4);
    in_enque_en  = 1'b1;
    in_ch        = 2'd1;
    in_data      = 32'hFF;
    out_deque_en = 1'b1;
    tick();
    in_enque_en  = 1'b0;
    out_deque_en = 1'b0;
    check("sim_full_occ_after", 64'(occ_of(occ_rr, 1)), 64'd3);
    check("sim_full_ready",     64'(rdy_rr), 64'hF);
    check("sim_full_head",      64'(dat_rr), 64'hF1);
`ifdef CTRL_BUF_MC_DROP_CNT_EN
    check("sim_full_drop", 64'(drop_rr), 64'd1);
`endif
    for (int i = 1; i < 4; i++) begin
      check("sim_drain_d", 64'(dat_rr), 64'hF0 + 64'(i));
      deq();
    end
    check("sim_drain_empty", 64'(vld_rr), 64'h0);

    // Simultaneous enqueue and dequeue at count 1 keeps the count
    enq(1, 32'h31);
    in_enque_en  = 1'b1;
    in_ch        = 2'd1;
    in_data      = 32'h32;
    out_deque_en = 1'b1;
    tick();
    in_enque_en  = 1'b0;
    out_deque_en = 1'b0;
    check("sim_mid_occ",  64'(occ_of(occ_rr, 1)), 64'd1);
    check("sim_mid_data", 64'(dat_rr), 64'h32);

    // Dequeue on empty is ignored; enqueue on empty still lands
    deq();
    check("empty_deq_valid", 64'(vld_rr), 64'h0);
    in_enque_en  = 1'b1;
    in_ch        = 2'd2;
    in_data      = 32'h77;
    out_deque_en = 1'b1;
    tick();
    in_enque_en  = 1'b0;
    out_deque_en = 1'b0;
    check("empty_sim_occ",  64'(occ_of(occ_rr, 2)), 64'd1);
    check("empty_sim_data", 64'(dat_rr), 64'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
